// File: rtl/psu_cntseq.sv
// Sequencer that plays one control-word sequence from psu_cntsrmem and issues each entry
// downstream with a valid/ready handshake. Optional looping is enabled by `define PSU_CNTSEQ_REPEAT_EN.
module psu_cntseq #(
  parameter int TIME_BW  = 8,
  parameter int CWD_BW   = 4,
  parameter int IDLEN_BW = 5
) (
  input  logic                clk,
  input  logic                rst,
`ifdef PSU_CNTSEQ_REPEAT_EN
  input  logic                repeat_seq,
`endif
  input  logic                start,
  input  logic [1:0]          sel_req,
  output logic                busy,
  output logic                done,
  output logic [1:0]          sel_cwdNtime,
  output logic                next_id,
  input  logic [TIME_BW-1:0]  timing,
  input  logic [CWD_BW-1:0]   cwd,
  input  logic [CWD_BW-1:0]   cwdsp,
  input  logic [IDLEN_BW-1:0] id_len,
  output logic [CWD_BW-1:0]   cwd_out,
  output logic [CWD_BW-1:0]   cwdsp_out,
  output logic                cwd_valid,
  input  logic                cwd_ready,
  output logic [IDLEN_BW-1:0] step_idx
);

  localparam logic [1:0] SELCNT_INIT = 2'd1;
  localparam logic [1:0] SELCNT_MEAS = 2'd2;
  localparam logic [1:0] SELCNT_RESM = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_HOLD, S_ADVANCE, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            sel_q, sel_d;
  logic [IDLEN_BW-1:0]   step_q, step_d;
  logic [TIME_BW-1:0]    cnt_q, cnt_d;
  logic [CWD_BW-1:0]     cwd_q, cwd_d;
  logic [CWD_BW-1:0]     cwdsp_q, cwdsp_d;
  logic                  valid_q, valid_d;
  logic                  sel_ok;
  logic                  last_step;
  logic                  repeat_hit;

`ifdef PSU_CNTSEQ_REPEAT_EN
  assign repeat_hit = repeat_seq;
`else
  assign repeat_hit = 1'b0;
`endif

  assign sel_ok    = (sel_req == SELCNT_INIT) || (sel_req == SELCNT_MEAS) ||
                     (sel_req == SELCNT_RESM);
  assign last_step = (step_q == (id_len - IDLEN_BW'(1)));

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      cwd_q   <= '0;
      cwdsp_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      cwd_q   <= cwd_d;
      cwdsp_q <= cwdsp_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the case leaves a latch.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    cwd_d   = cwd_q;
    cwdsp_d = cwdsp_q;
    valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && sel_ok) begin
          sel_d   = sel_req;
          step_d  = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = (id_len == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        if (cwd_ready) begin
          cwd_d   = cwd;
          cwdsp_d = cwdsp;
          valid_d = 1'b1;
          // A zero hold time still spends one cycle in HOLD.
          cnt_d   = (timing == '0) ? TIME_BW'(1) : timing;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        cnt_d = cnt_q - TIME_BW'(1);
        if (cnt_q == TIME_BW'(1)) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (last_step) begin
          step_d  = '0;
          state_d = repeat_hit ? S_ISSUE : S_DONE;
        end else begin
          step_d  = step_q + IDLEN_BW'(1);
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        sel_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    next_id = (state_q == S_ADVANCE);
    done    = (state_q == S_DONE) ||
              ((state_q == S_ADVANCE) && last_step && repeat_hit);
  end

  assign sel_cwdNtime = sel_q;
  assign step_idx     = step_q;
  assign cwd_out      = cwd_q;
  assign cwdsp_out    = cwdsp_q;
  assign cwd_valid    = valid_q;

endmodule

// File: tb/tb_psu_cntseq.sv
// Directed bench for psu_cntseq with a behavioural stand-in for the control-word store.
module tb_psu_cntseq;

  localparam logic [1:0] SEL_INIT = 2'd1;
  localparam logic [1:0] SEL_MEAS = 2'd2;
  localparam logic [1:0] SEL_RESM = 2'd3;
  localparam logic [3:0] CWD_H    = 4'hC;
  localparam logic [3:0] CWD_CZ0  = 4'hD;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] sel_req;
  logic       busy, done, next_id, cwd_valid, cwd_ready;
  logic [1:0] sel_cwdNtime;
  logic [7:0] timing;
  logic [3:0] cwd, cwdsp, cwd_out, cwdsp_out;
  logic [4:0] id_len, step_idx;

  int checks   = 0;
  int failures = 0;

  psu_cntseq dut (
    .clk(clk), .rst(rst), .start(start), .sel_req(sel_req),
    .busy(busy), .done(done), .sel_cwdNtime(sel_cwdNtime), .next_id(next_id),
    .timing(timing), .cwd(cwd), .cwdsp(cwdsp), .id_len(id_len),
    .cwd_out(cwd_out), .cwdsp_out(cwdsp_out), .cwd_valid(cwd_valid),
    .cwd_ready(cwd_ready), .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  // Store stand-in: per-sequence tables and a rotating entry pointer.
  logic [7:0] t_tab [4][20];
  logic [3:0] c_tab [4][20];
  logic [3:0] s_tab [4][20];
  logic [4:0] len_tab [4];
  logic [4:0] sidx;

  assign timing = t_tab[sel_cwdNtime][sidx];
  assign cwd    = c_tab[sel_cwdNtime][sidx];
  assign cwdsp  = s_tab[sel_cwdNtime][sidx];
  assign id_len = len_tab[sel_cwdNtime];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sidx <= '0;
    else if (next_id) sidx <= (sidx + 5'd1 == id_len) ? 5'd0 : sidx + 5'd1;
  end

  typedef struct {
    logic        start;
    logic [1:0]  sel;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [18:0] pk(input logic b, d, n, v, input logic [1:0] s,
                                     input logic [4:0] st, input logic [3:0] c, cs);
    return {b, d, n, v, s, st, c, cs};
  endfunction

  function automatic logic [18:0] obs();
    return {busy, done, next_id, cwd_valid, sel_cwdNtime, step_idx, cwd_out, cwdsp_out};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays one whole sequence with cwd_ready high, counting pulses until done.
  task automatic run_seq(input logic [1:0] s, output int nv, output int nn, output int nd,
                         output logic [3:0] c0, output logic [3:0] c1, output bit ok);
    nv = 0; nn = 0; nd = 0; c0 = 'x; c1 = 'x; ok = 1'b0;
    cwd_ready = 1'b1;
    start = 1'b1; sel_req = s;
    tick();
    start = 1'b0; sel_req = 2'd0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      if (cwd_valid) begin
        if (nv == 0) c0 = cwd_out;
        if (nv == 1) c1 = cwd_out;
        nv++;
      end
      if (next_id) nn++;
      if (done) begin nd++; ok = 1'b1; end
    end
    tick();
  endtask

  int nv, nn, nd;
  logic [3:0] c0, c1;
  bit ok;

  initial begin
    for (int s = 0; s < 4; s++) begin
      len_tab[s] = '0;
      for (int i = 0; i < 20; i++) begin
        t_tab[s][i] = 8'd1; c_tab[s][i] = 4'(i); s_tab[s][i] = 4'(i + 3);
      end
    end
    len_tab[SEL_INIT] = 5'd3;
    t_tab[SEL_INIT][0] = 8'd2; t_tab[SEL_INIT][1] = 8'd1; t_tab[SEL_INIT][2] = 8'd0;
    c_tab[SEL_INIT][0] = 4'd1; c_tab[SEL_INIT][1] = 4'd2; c_tab[SEL_INIT][2] = 4'd3;
    s_tab[SEL_INIT][0] = 4'd9; s_tab[SEL_INIT][1] = 4'd10; s_tab[SEL_INIT][2] = 4'd11;
    len_tab[SEL_MEAS] = 5'd2;
    c_tab[SEL_MEAS][0] = CWD_H; c_tab[SEL_MEAS][1] = 4'd6;
    len_tab[SEL_RESM] = 5'd20;
    c_tab[SEL_RESM][0] = CWD_H; c_tab[SEL_RESM][1] = CWD_CZ0;
    t_tab[SEL_RESM][5] = 8'd4;

    // INIT with timings 2,1,0: issues 4 then 3 cycles apart, done right after the third next_id.
    vecs[0]  = '{1'b1, SEL_INIT, pk(1,0,0,0,1,0,0,0)};
    vecs[1]  = '{1'b0, 2'd0,     pk(1,0,0,0,1,0,0,0)};
    vecs[2]  = '{1'b0, 2'd0,     pk(1,0,0,1,1,0,1,9)};
    vecs[3]  = '{1'b1, SEL_MEAS, pk(1,0,0,0,1,0,1,9)};
    vecs[4]  = '{1'b0, 2'd0,     pk(1,0,1,0,1,0,1,9)};
    vecs[5]  = '{1'b0, 2'd0,     pk(1,0,0,0,1,1,1,9)};
    vecs[6]  = '{1'b0, 2'd0,     pk(1,0,0,1,1,1,2,10)};
    vecs[7]  = '{1'b0, 2'd0,     pk(1,0,1,0,1,1,2,10)};
    vecs[8]  = '{1'b0, 2'd0,     pk(1,0,0,0,1,2,2,10)};
    vecs[9]  = '{1'b0, 2'd0,     pk(1,0,0,1,1,2,3,11)};
    vecs[10] = '{1'b1, SEL_RESM, pk(1,0,1,0,1,2,3,11)};
    vecs[11] = '{1'b0, 2'd0,     pk(1,1,0,0,1,0,3,11)};
    vecs[12] = '{1'b1, SEL_RESM, pk(0,0,0,0,0,0,3,11)};
    vecs[13] = '{1'b0, 2'd0,     pk(0,0,0,0,0,0,3,11)};

    rst = 1'b1; start = 1'b0; sel_req = 2'd0; cwd_ready = 1'b1;
    #1;
    check("reset_state", 32'(obs()), 32'(pk(0,0,0,0,0,0,0,0)));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("idle_%0d", i), {busy, next_id, cwd_valid, sel_cwdNtime}, 32'd0);
    end

    for (int i = 0; i < 14; i++) begin
      start = vecs[i].start; sel_req = vecs[i].sel;
      tick();
      check($sformatf("init_vec_%0d", i), 32'(obs()), 32'(vecs[i].exp));
    end
    start = 1'b0; sel_req = 2'd0;

    // Invalid select code never leaves IDLE.
    start = 1'b1; sel_req = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bad_sel_%0d", i), {busy, sel_cwdNtime}, 32'd0);
    end
    start = 1'b0;

    // Backpressure: no issue while cwd_ready is low, issue on the edge it rises.
    cwd_ready = 1'b0; start = 1'b1; sel_req = SEL_MEAS;
    tick();
    start = 1'b0; sel_req = 2'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_wait_%0d", i), {busy, next_id, cwd_valid, step_idx}, {1'b1, 2'b00, 5'd0});
    end
    cwd_ready = 1'b1;
    tick();
    check("bp_issue", {cwd_valid, cwd_out}, {1'b1, CWD_H});
    nn = 0; ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick();
      if (next_id) nn++;
      if (done) ok = 1'b1;
    end
    check("bp_done_seen", 32'(ok), 32'd1);
    check("bp_next_id_count", nn, 2);
    tick();

    // Long sequence, then a different one to confirm the store is back at entry 0.
    run_seq(SEL_RESM, nv, nn, nd, c0, c1, ok);
    check("resm_done_seen", 32'(ok), 32'd1);
    check("resm_valid_count", nv, 20);
    check("resm_next_id_count", nn, 20);
    check("resm_first_cwd", c0, CWD_H);
    check("resm_second_cwd", c1, CWD_CZ0);
    run_seq(SEL_MEAS, nv, nn, nd, c0, c1, ok);
    check("meas_first_cwd", c0, CWD_H);
    check("meas_next_id_count", nn, 2);
    check("meas_idle_after", {busy, sel_cwdNtime}, 32'd0);

    // Async reset in the middle of HOLD for step 5.
    start = 1'b1; sel_req = SEL_RESM;
    tick();
    start = 1'b0; sel_req = 2'd0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      if (cwd_valid && step_idx == 5'd5) ok = 1'b1;
    end
    check("rst_reached_step5", 32'(ok), 32'd1);
    tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_hold", 32'(obs()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_seq(SEL_INIT, nv, nn, nd, c0, c1, ok);
    check("after_rst_first_cwd", c0, 4'd1);
    check("after_rst_valid_count", nv, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
